// File: rtl/hb_interp_fir.sv
// Halfband interpolate-by-2 FIR for complex I/Q samples.
// Every accepted input produces two outputs: the even phase is the centre
// tap (d3, unity gain) and the odd phase is a 6-tap symmetric FIR with
// round-half-up and saturation. I and Q share one ACCEPT/HOLD controller.
module hb_interp_fir #(
    parameter int WIDTH = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic signed [WIDTH-1:0] i_inph_data,
    input  logic signed [WIDTH-1:0] i_quad_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic signed [WIDTH-1:0] o_inph_data,
    output logic signed [WIDTH-1:0] o_quad_data,
    output logic                    o_valid
);

    localparam int ACC_W = WIDTH + 10;

    localparam logic signed [ACC_W-1:0] C_OUT = ACC_W'(3);
    localparam logic signed [ACC_W-1:0] C_MID = ACC_W'(25);
    localparam logic signed [ACC_W-1:0] C_CTR = ACC_W'(150);
    localparam logic signed [ACC_W-1:0] C_RND = ACC_W'(128);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_ACCEPT,
        ST_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;

    logic signed [WIDTH-1:0] r_inph_dly [6];
    logic signed [WIDTH-1:0] r_quad_dly [6];

    logic                    r_odd_pend;
    logic                    r_valid;
    logic signed [WIDTH-1:0] r_inph_out;
    logic signed [WIDTH-1:0] r_quad_out;

    logic signed [WIDTH-1:0] w_inph_odd;
    logic signed [WIDTH-1:0] w_quad_odd;

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [WIDTH-1:0] v);
        return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Odd phase: (3*(d0+d5) - 25*(d1+d4) + 150*(d2+d3) + 128) >>> 8, saturated.
    function automatic logic signed [WIDTH-1:0] odd_phase(
        input logic signed [WIDTH-1:0] d0,
        input logic signed [WIDTH-1:0] d1,
        input logic signed [WIDTH-1:0] d2,
        input logic signed [WIDTH-1:0] d3,
        input logic signed [WIDTH-1:0] d4,
        input logic signed [WIDTH-1:0] d5
    );
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] shr;
        logic signed [WIDTH-1:0] res;
        acc = C_OUT * (sx(d0) + sx(d5))
            - C_MID * (sx(d1) + sx(d4))
            + C_CTR * (sx(d2) + sx(d3))
            + C_RND;
        shr = acc >>> 8;
        if (shr > SAT_MAX) begin
            res = SAT_MAX[WIDTH-1:0];
        end else if (shr < SAT_MIN) begin
            res = SAT_MIN[WIDTH-1:0];
        end else begin
            res = shr[WIDTH-1:0];
        end
        return res;
    endfunction

    assign w_inph_odd = odd_phase(r_inph_dly[0], r_inph_dly[1], r_inph_dly[2],
                                  r_inph_dly[3], r_inph_dly[4], r_inph_dly[5]);
    assign w_quad_odd = odd_phase(r_quad_dly[0], r_quad_dly[1], r_quad_dly[2],
                                  r_quad_dly[3], r_quad_dly[4], r_quad_dly[5]);

    assign w_accept = i_valid & o_ready;

    // Controller state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and ready: accept in ACCEPT, then one mandatory HOLD cycle.
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                o_ready = ~i_reset;
                if (i_valid && !i_reset) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_ACCEPT;
            end
            default: begin
                w_state_nxt = ST_ACCEPT;
            end
        endcase
    end

    // Delay lines and output phases. The HOLD cycle registers the even output;
    // the following cycle registers the odd output from the same, still
    // unshifted, delay line (the next shift lands on that same edge at the earliest).
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_inph_dly <= '{default: '0};
            r_quad_dly <= '{default: '0};
            r_odd_pend <= 1'b0;
            r_valid    <= 1'b0;
            r_inph_out <= '0;
            r_quad_out <= '0;
        end else begin
            if (w_accept) begin
                r_inph_dly[0] <= i_inph_data;
                r_quad_dly[0] <= i_quad_data;
                for (int unsigned k = 1; k < 6; k++) begin
                    r_inph_dly[k] <= r_inph_dly[k-1];
                    r_quad_dly[k] <= r_quad_dly[k-1];
                end
            end
            r_valid    <= 1'b0;
            r_odd_pend <= 1'b0;
            if (r_state == ST_HOLD) begin
                r_valid    <= 1'b1;
                r_odd_pend <= 1'b1;
                r_inph_out <= r_inph_dly[3];
                r_quad_out <= r_quad_dly[3];
            end else if (r_odd_pend) begin
                r_valid    <= 1'b1;
                r_inph_out <= w_inph_odd;
                r_quad_out <= w_quad_odd;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_inph_data = r_inph_out;
    assign o_quad_data = r_quad_out;

endmodule

// File: tb/tb_hb_interp_fir.sv
// Directed bench for hb_interp_fir: reset, impulse, DC, saturation,
// throughput and backpressure/mid-stream reset, with hand-computed values.
module tb_hb_interp_fir;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    vin;
    logic signed [WIDTH-1:0] din_i;
    logic signed [WIDTH-1:0] din_q;
    logic                    rdy;
    logic                    vout;
    logic signed [WIDTH-1:0] dout_i;
    logic signed [WIDTH-1:0] dout_q;

    hb_interp_fir #(.WIDTH(WIDTH)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_inph_data (din_i),
        .i_quad_data (din_q),
        .i_valid     (vin),
        .o_ready     (rdy),
        .o_inph_data (dout_i),
        .o_quad_data (dout_q),
        .o_valid     (vout)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int got_i[$];
    int got_q[$];
    int first_vcyc    = 0;
    int last_vcyc     = 0;
    int first_acc_cyc = 0;
    int stall_err     = 0;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Output collector, sampled away from the active edge.
    always @(negedge clk) begin
        if (vout) begin
            if (got_i.size() == 0) first_vcyc = cyc;
            last_vcyc = cyc;
            got_i.push_back(int'(dout_i));
            got_q.push_back(int'(dout_q));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        #1;
        got_i.delete();
        got_q.delete();
        stall_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vin = 1'b0; din_i = '0; din_q = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", int'(vout), 0);
        check("rst_ready", int'(rdy), 0);
        check("rst_data_i", int'(dout_i), 0);
        check("rst_data_q", int'(dout_q), 0);
        rst = 1'b0;
        clear_log();
    endtask

    // Drive a sample list; with hold_valid, i_valid stays high between samples.
    task automatic send(input int qi[$], input int qq[$], input bit hold_valid);
        int n;
        for (int i = 0; i < qi.size(); i++) begin
            @(negedge clk);
            vin   = 1'b1;
            din_i = WIDTH'(qi[i]);
            din_q = WIDTH'(qq[i]);
            n = 0;
            while (!rdy && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) check("accept_seen", int'(rdy), 1);
            if (i == 0) first_acc_cyc = cyc;
            if (i > 0 && hold_valid && n != 1) stall_err++;
            if (!hold_valid || i == qi.size() - 1) begin
                @(posedge clk);
                #1 vin = 1'b0;
            end
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -99999;
    endfunction

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int qi[$];
        int qq[$];
        int exp_imp[12];
        int bad;
        rst = 1'b1; vin = 1'b0; din_i = '0; din_q = '0;

        // 1. Reset, then idle for 1000 cycles.
        do_reset();
        @(negedge clk);
        check("ready_after_rst", int'(rdy), 1);
        drain(1000);
        check("idle_valid_count", got_i.size(), 0);

        // 2. Impulse with i_valid held high.
        do_reset();
        qi = '{25600, 0, 0, 0, 0, 0};
        qq = '{-25600, 0, 0, 0, 0, 0};
        send(qi, qq, 1'b1);
        drain(8);
        exp_imp = '{0, 300, 0, -2500, 0, 15000, 25600, 15000, 0, -2500, 0, 300};
        check("imp_count", got_i.size(), 12);
        check("imp_latency", first_vcyc - first_acc_cyc, 2);
        check("imp_stall", stall_err, 0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("imp_i%0d", k), at(got_i, k), exp_imp[k]);
            check($sformatf("imp_q%0d", k), at(got_q, k), -exp_imp[k]);
        end

        // 3. DC gain on both phases after fill.
        do_reset();
        qi.delete(); qq.delete();
        for (int n = 0; n < 100; n++) begin
            qi.push_back(1000);
            qq.push_back(-1000);
        end
        send(qi, qq, 1'b1);
        drain(8);
        check("dc_count", got_i.size(), 200);
        bad = 0;
        for (int k = 10; k < got_i.size(); k++) begin
            if (got_i[k] != 1000 || got_q[k] != -1000) bad++;
        end
        check("dc_bad_samples", bad, 0);
        check("dc_last_i", at(got_i, 199), 1000);
        check("dc_last_q", at(got_q, 199), -1000);

        // 4. Saturation in both directions.
        do_reset();
        qi = '{32767, -32768, 32767, 32767, -32768, 32767};
        qq = '{-32767, 32767, -32767, -32767, 32767, -32767};
        send(qi, qq, 1'b1);
        drain(8);
        check("sat_count", got_i.size(), 12);
        check("sat_even_i", at(got_i, 10), 32767);
        check("sat_even_q", at(got_q, 10), -32767);
        check("sat_odd_pos", at(got_i, 11), 32767);
        check("sat_odd_neg", at(got_q, 11), -32768);

        // 5. Throughput with a complex tone at 0.301 of input rate.
        do_reset();
        qi.delete(); qq.delete();
        for (int n = 0; n < 10000; n++) begin
            qi.push_back($rtoi(8000.0 * $cos(6.283185307 * 0.301 * n)));
            qq.push_back($rtoi(8000.0 * $sin(6.283185307 * 0.301 * n)));
        end
        send(qi, qq, 1'b1);
        drain(8);
        check("tp_count", got_i.size(), 20000);
        check("tp_continuous", last_vcyc - first_vcyc + 1, 20000);
        check("tp_ready_toggle", stall_err, 0);

        // 6a. Backpressure: i_valid during HOLD is not consumed.
        do_reset();
        @(negedge clk);
        vin = 1'b1; din_i = 16'sd100; din_q = '0;
        check("bp_ready_a", int'(rdy), 1);
        @(negedge clk);
        din_i = 16'sd200;
        check("bp_ready_hold", int'(rdy), 0);
        @(negedge clk);
        check("bp_ready_b", int'(rdy), 1);
        @(posedge clk);
        #1 vin = 1'b0;
        drain(8);
        check("bp_count", got_i.size(), 4);
        check("bp_i0", at(got_i, 0), 0);
        check("bp_i1", at(got_i, 1), 1);
        check("bp_i2", at(got_i, 2), 0);
        check("bp_i3", at(got_i, 3), -7);
        check("bp_q3", at(got_q, 3), 0);

        // 6b. One-cycle reset mid-stream discards pending outputs.
        do_reset();
        qi.delete(); qq.delete();
        for (int n = 0; n < 8; n++) begin
            qi.push_back(5000);
            qq.push_back(-5000);
        end
        send(qi, qq, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_pre_count", got_i.size(), 14);
        check("mid_rst_valid", int'(vout), 0);
        check("mid_rst_ready", int'(rdy), 0);
        check("mid_rst_data_i", int'(dout_i), 0);
        check("mid_rst_data_q", int'(dout_q), 0);
        rst = 1'b0;
        clear_log();
        drain(20);
        check("mid_residual", got_i.size(), 0);
        check("mid_ready_after", int'(rdy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
